drr_sched: RTL

//  Deficit-round-robin scheduler sharing one 64-bit output among 2**NUM_IN_LOG2 show-ahead input FIFOs.

---
 rtl/fq_pkg.sv | 29 ++
 rtl/drr_sched_credit.sv | 39 +++
 rtl/drr_sched.sv | 134 +++++++++++++
 3 files changed

// File: rtl/fq_pkg.sv
// Shared types and helpers for the deficit-round-robin scheduler and its credit bank.
package fq_pkg;

  localparam int NUM_IN_LOG2 = 3;
  localparam int DEF_W       = 9;

  typedef logic [NUM_IN_LOG2-1:0] chan_t;
  typedef logic [7:0]             len_t;
  typedef logic [DEF_W-1:0]       def_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    SEND = 2'd2
  } sched_state_t;

  typedef enum logic [1:0] {
    CR_NOP = 2'd0,
    CR_CLR = 2'd1,
    CR_ADD = 2'd2,
    CR_SUB = 2'd3
  } credit_op_t;

  // A zero length field still occupies one word on the wire.
  function automatic len_t burst_len(input logic [7:0] hdr);
    return (hdr == 8'd0) ? 8'd1 : hdr;
  endfunction

endpackage

// File: rtl/drr_sched_credit.sv
// Per-channel deficit counters; one clear/add/subtract operation per cycle at a single index.
module drr_credit
  import fq_pkg::*;
#(
  parameter int NUM_IN_LOG2 = 3,
  parameter int DEF_W       = 9,
  parameter int QUANTUM     = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  credit_op_t             op,
  input  logic [NUM_IN_LOG2-1:0] idx,
  input  logic [7:0]             sub_val,
  output logic [DEF_W-1:0]       deficit
);

  localparam int N = 1 << NUM_IN_LOG2;
  localparam logic [DEF_W:0] Q_EXT = (DEF_W+1)'(QUANTUM);

  logic [DEF_W-1:0] def_q [N];
  logic [DEF_W:0]   sum;

  assign deficit = def_q[idx];
  assign sum     = {1'b0, def_q[idx]} + Q_EXT;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) def_q[i] <= '0;
    end else begin
      case (op)
        CR_CLR:  def_q[idx] <= '0;
        CR_ADD:  def_q[idx] <= sum[DEF_W] ? '1 : sum[DEF_W-1:0];
        CR_SUB:  def_q[idx] <= def_q[idx] - DEF_W'(sub_val);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/drr_sched.sv
// Deficit-round-robin burst scheduler: N show-ahead FIFOs share one valid/ready output,
// whole bursts granted against per-channel credit.
module drr_sched
  import fq_pkg::*;
#(
  parameter int NUM_IN_LOG2 = 3,
  parameter int DATA_W      = 64,
  parameter int QUANTUM     = 16,
  parameter int DEF_W       = 9
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic [(1<<NUM_IN_LOG2)-1:0]                  fifo_empty,
  input  logic [(1<<NUM_IN_LOG2)-1:0][DATA_W-1:0]      fifo_data,
  output logic [(1<<NUM_IN_LOG2)-1:0]                  fifo_rdreq,
  output logic                                         out_valid,
  input  logic                                         out_ready,
  output logic [DATA_W-1:0]                            out_data,
  output logic                                         out_sop,
  output logic                                         out_eop,
  output logic [NUM_IN_LOG2-1:0]                       out_chan,
  output logic                                         busy
);

  sched_state_t            state, state_nxt;
  logic [NUM_IN_LOG2-1:0]  ptr;
  logic                    fresh;
  len_t                    cnt;
  len_t                    len_q;
  len_t                    head_len;
  logic [DEF_W-1:0]        deficit;
  credit_op_t              credit_op;
  logic                    any_pending;
  logic                    head_valid;
  logic                    fits;
  logic                    xfer;
  logic                    last;

  assign any_pending = |(~fifo_empty);
  assign head_valid  = !fifo_empty[ptr];
  assign head_len    = burst_len(fifo_data[ptr][7:0]);
  assign fits        = DEF_W'(head_len) <= deficit;
  assign xfer        = (state == SEND) && head_valid && out_ready;
  assign last        = (cnt == len_q - 8'd1);

  drr_credit #(
    .NUM_IN_LOG2 (NUM_IN_LOG2),
    .DEF_W       (DEF_W),
    .QUANTUM     (QUANTUM)
  ) u_credit (
    .clk     (clk),
    .rst     (rst),
    .op      (credit_op),
    .idx     (ptr),
    .sub_val (head_len),
    .deficit (deficit)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (any_pending) state_nxt = SCAN;
      SCAN: begin
        if (fifo_empty[ptr]) begin
          if (!any_pending) state_nxt = IDLE;
        end else if (!fresh && fits) begin
          state_nxt = SEND;
        end
      end
      SEND: if (xfer && last) state_nxt = SCAN;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    credit_op  = CR_NOP;
    out_valid  = 1'b0;
    out_sop    = 1'b0;
    out_eop    = 1'b0;
    out_data   = '0;
    out_chan   = ptr;
    fifo_rdreq = '0;
    busy       = 1'b0;
    case (state)
      SCAN: begin
        if (fifo_empty[ptr])  credit_op = CR_CLR;
        else if (fresh)       credit_op = CR_ADD;
        else if (fits)        credit_op = CR_SUB;
      end
      SEND: begin
        busy            = 1'b1;
        out_valid       = head_valid;
        out_data        = fifo_data[ptr];
        out_sop         = (cnt == 8'd0);
        out_eop         = last;
        fifo_rdreq[ptr] = xfer;
      end
      default: ;
    endcase
  end

  // Pointer, visit flag and burst bookkeeping; fresh stays clear after a burst so the
  // same channel keeps spending what is left of its deficit before moving on.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr   <= '0;
      fresh <= 1'b1;
      cnt   <= '0;
      len_q <= '0;
    end else begin
      case (state)
        SCAN: begin
          if (fifo_empty[ptr] || (!fresh && !fits)) begin
            ptr   <= ptr + 1'b1;
            fresh <= 1'b1;
          end else if (fresh) begin
            fresh <= 1'b0;
          end else begin
            len_q <= head_len;
            cnt   <= '0;
          end
        end
        SEND: if (xfer) cnt <= cnt + 8'd1;
        default: ;
      endcase
    end
  end

endmodule
